// File: rtl/float_copro_pkg.sv
// Shared constants and types for the LM32 floating-point coprocessor datapath.
package float_copro_pkg;

    localparam int unsigned OPC_W     = 11;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned MAN_W     = 23;
    localparam int unsigned BIAS      = 127;
    localparam int unsigned EXT_EXP_W = 12;
    // Working significand frame: leading one lands on bit 26, bit 27 holds a carry.
    localparam int unsigned FRAME_W   = 28;

    localparam logic [OPC_W-1:0] OP_ADD = 11'd0;
    localparam logic [OPC_W-1:0] OP_SUB = 11'd1;
    localparam logic [OPC_W-1:0] OP_MUL = 11'd2;
    localparam logic [OPC_W-1:0] OP_DIV = 11'd3;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG = 31'h7F80_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;   // hidden bit at the top
    } ufloat_t;

    function automatic ufloat_t unpack_f32(input logic [31:0] f);
        ufloat_t u;
        u.sign = f[31];
        u.exp  = f[30:23];
        u.man  = {(f[30:23] != 8'd0), f[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/float_copro_datapath_if.sv
// Operand/result bundle between the coprocessor controller and its datapath.
interface float_copro_datapath_if;
    import float_copro_pkg::*;

    logic [OPC_W-1:0] opcode;
    logic [31:0]      op0;
    logic [31:0]      op1;
    logic [31:0]      resultat;

    modport master (output opcode, output op0, output op1, input resultat);
    modport slave  (input opcode, input op0, input op1, output resultat);
endinterface

// File: rtl/fp_round_pack.sv
// Normalize a working significand, round to nearest even, clamp overflow/underflow and pack to binary32.
module fp_round_pack
    import float_copro_pkg::*;
(
    input  logic                        sign_i,
    input  logic signed [EXT_EXP_W-1:0] exp_i,
    input  logic [FRAME_W-1:0]          man_i,
    input  logic                        sticky_i,
    output logic [31:0]                 result_c
);

    logic [4:0]                  lead;
    logic [4:0]                  sh;
    logic [FRAME_W-2:0]          norm;
    logic                        st;
    logic                        rnd_up;
    logic [24:0]                 rnd;
    logic [23:0]                 sig;
    logic signed [EXT_EXP_W-1:0] exp_n;
    logic signed [EXT_EXP_W-1:0] exp_r;

    // Leading-one position; the highest set bit wins.
    always_comb begin
        lead = 5'd0;
        for (int i = 0; i < int'(FRAME_W); i++) begin
            if (man_i[i]) lead = 5'(i);
        end
    end

    always_comb begin
        sh    = 5'd0;
        norm  = '0;
        st    = sticky_i;
        exp_n = exp_i;
        if (man_i[FRAME_W-1]) begin
            norm  = man_i[FRAME_W-1:1];
            st    = sticky_i | man_i[0];
            exp_n = exp_i + 12'sd1;
        end else begin
            sh    = 5'd26 - lead;
            norm  = 27'(man_i << sh);
            exp_n = exp_i - $signed({7'd0, sh});
        end

        // Bits [26:3] are the significand, bit 2 guard, bits [1:0] fold into sticky.
        rnd_up = norm[2] & (st | norm[1] | norm[0] | norm[3]);
        rnd    = {1'b0, norm[26:3]} + 25'(rnd_up);
        if (rnd[24]) begin
            sig   = rnd[24:1];
            exp_r = exp_n + 12'sd1;
        end else begin
            sig   = rnd[23:0];
            exp_r = exp_n;
        end

        if (man_i == '0) begin
            result_c = {sign_i, 31'd0};
        end else if (exp_r >= 12'sd255) begin
            result_c = {sign_i, INF_MAG};
        end else if (exp_r <= 12'sd0) begin
            result_c = {sign_i, 31'd0};
        end else begin
            result_c = {sign_i, exp_r[7:0], sig[22:0]};
        end
    end

endmodule

// File: rtl/float_copro_datapath.sv
// Single-precision add/sub/mul/div core with a free-running result register; the controller owns the latency.
module float_copro_datapath
    import float_copro_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    float_copro_datapath_if.slave  bus
);

    ufloat_t ua, ub;
    logic    sb_eff;
    logic    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic    is_add, is_mul, is_div, invalid;

    always_comb begin
        ua      = unpack_f32(bus.op0);
        ub      = unpack_f32(bus.op1);
        is_add  = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB);
        is_mul  = (bus.opcode == OP_MUL);
        is_div  = (bus.opcode == OP_DIV);
        invalid = !(is_add || is_mul || is_div);
        sb_eff  = ub.sign ^ (bus.opcode == OP_SUB);
        a_zero  = (ua.exp == 8'd0);
        b_zero  = (ub.exp == 8'd0);
        a_inf   = (ua.exp == 8'hFF) && (ua.man[22:0] == 23'd0);
        b_inf   = (ub.exp == 8'hFF) && (ub.man[22:0] == 23'd0);
        a_nan   = (ua.exp == 8'hFF) && (ua.man[22:0] != 23'd0);
        b_nan   = (ub.exp == 8'hFF) && (ub.man[22:0] != 23'd0);
    end

    // Special operands bypass the arithmetic paths entirely.
    logic        special_hit;
    logic [31:0] special_val;
    logic        s_prod;

    always_comb begin
        special_hit = 1'b1;
        special_val = QNAN;
        s_prod      = ua.sign ^ ub.sign;
        if (a_nan || b_nan) begin
            special_val = QNAN;
        end else if (is_add) begin
            if (a_inf && b_inf && (ua.sign != sb_eff)) special_val = QNAN;
            else if (a_inf)                            special_val = {ua.sign, INF_MAG};
            else if (b_inf)                            special_val = {sb_eff, INF_MAG};
            else if (a_zero && b_zero)                 special_val = {ua.sign & sb_eff, 31'd0};
            else if (a_zero)                           special_val = {sb_eff, bus.op1[30:0]};
            else if (b_zero)                           special_val = bus.op0;
            else                                       special_hit = 1'b0;
        end else if (is_mul) begin
            if ((a_inf && b_zero) || (a_zero && b_inf)) special_val = QNAN;
            else if (a_inf || b_inf)                    special_val = {s_prod, INF_MAG};
            else if (a_zero || b_zero)                  special_val = {s_prod, 31'd0};
            else                                        special_hit = 1'b0;
        end else if (is_div) begin
            if ((a_zero && b_zero) || (a_inf && b_inf)) special_val = QNAN;
            else if (b_zero || a_inf)                   special_val = {s_prod, INF_MAG};
            else if (b_inf || a_zero)                   special_val = {s_prod, 31'd0};
            else                                        special_hit = 1'b0;
        end else begin
            special_hit = 1'b0;
        end
    end

    // Add/sub: swap so the larger magnitude leads, align the other with guard/round/sticky.
    logic               a_big, eff_sub, al_sticky, as_sign;
    logic [EXP_W-1:0]   e_big, e_small, ediff;
    logic [MAN_W:0]     m_big, m_small;
    logic [4:0]         shamt;
    logic [53:0]        al_wide;
    logic [26:0]        a_ext, b_al;
    logic [FRAME_W-1:0] as_sum;

    always_comb begin
        a_big     = {ua.exp, ua.man[22:0]} >= {ub.exp, ub.man[22:0]};
        eff_sub   = ua.sign ^ sb_eff;
        e_big     = a_big ? ua.exp : ub.exp;
        e_small   = a_big ? ub.exp : ua.exp;
        m_big     = a_big ? ua.man : ub.man;
        m_small   = a_big ? ub.man : ua.man;
        ediff     = e_big - e_small;
        shamt     = (ediff > 8'd27) ? 5'd27 : ediff[4:0];
        al_wide   = {m_small, 30'd0} >> shamt;
        b_al      = al_wide[53:27];
        al_sticky = |al_wide[26:0];
        a_ext     = {m_big, 3'b000};
        if (eff_sub) as_sum = {1'b0, a_ext} - {1'b0, b_al} - 28'(al_sticky);
        else         as_sum = {1'b0, a_ext} + {1'b0, b_al};
        as_sign   = ((as_sum == '0) && !al_sticky) ? 1'b0 : (a_big ? ua.sign : sb_eff);
    end

    logic [47:0] prod;

    always_comb begin
        prod = 48'(ua.man) * 48'(ub.man);
    end

    // Restoring division: 27 quotient bits put the leading one on bit 26 or 25.
    logic [26:0] quo;
    logic [25:0] rem;

    always_comb begin
        quo = '0;
        rem = 26'(ua.man);
        for (int i = 26; i >= 0; i--) begin
            if (rem >= 26'(ub.man)) begin
                quo[i] = 1'b1;
                rem    = rem - 26'(ub.man);
            end
            if (i != 0) rem = rem << 1;
        end
    end

    logic                        rp_sign, rp_sticky;
    logic signed [EXT_EXP_W-1:0] rp_exp, ea_s, eb_s;
    logic [FRAME_W-1:0]          rp_man;
    logic [31:0]                 rp_result;

    always_comb begin
        ea_s      = $signed({4'd0, ua.exp});
        eb_s      = $signed({4'd0, ub.exp});
        rp_sign   = 1'b0;
        rp_exp    = '0;
        rp_man    = '0;
        rp_sticky = 1'b0;
        if (is_add) begin
            rp_sign   = as_sign;
            rp_exp    = $signed({4'd0, e_big});
            rp_man    = as_sum;
            rp_sticky = al_sticky;
        end else if (is_mul) begin
            rp_sign   = s_prod;
            rp_exp    = ea_s + eb_s - 12'sd127;
            rp_man    = prod[47:20];
            rp_sticky = |prod[19:0];
        end else if (is_div) begin
            rp_sign   = s_prod;
            rp_exp    = ea_s - eb_s + 12'sd127;
            rp_man    = {1'b0, quo};
            rp_sticky = (rem != '0);
        end
    end

    fp_round_pack u_round_pack (
        .sign_i   (rp_sign),
        .exp_i    (rp_exp),
        .man_i    (rp_man),
        .sticky_i (rp_sticky),
        .result_c (rp_result)
    );

    logic [31:0] resultat_d, resultat_q;

    always_comb begin
        resultat_d = rp_result;
        if (invalid)          resultat_d = 32'd0;
        else if (special_hit) resultat_d = special_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) resultat_q <= 32'd0;
        else        resultat_q <= resultat_d;
    end

    assign bus.resultat = resultat_q;

endmodule

// File: tb/tb_float_copro_datapath.sv
// Scoreboard bench for float_copro_datapath: expected words queued at drive time, popped one edge later.
module tb_float_copro_datapath;
    import float_copro_pkg::*;

    logic clk;
    logic rst_n;
    float_copro_datapath_if bus ();

    float_copro_datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    string       nm_q[$];

    task automatic push_vec(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e, input string nm);
        @(negedge clk);
        bus.opcode = op;
        bus.op0    = a;
        bus.op1    = b;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        string       nm;
        rst_n      = 1'b0;
        bus.opcode = OP_ADD;
        bus.op0    = 32'h3F80_0000;
        bus.op1    = 32'h4000_0000;
        #1;
        n_checks++;
        if (bus.resultat !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_initial: got %08h expected 00000000", bus.resultat);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.resultat !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_held: got %08h expected 00000000", bus.resultat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(32'h4040_0000);
        nm_q.push_back("reset_release_add");
        @(posedge clk);
        #1;
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        n_checks++;
        if (bus.resultat !== e) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, bus.resultat, e);
        end
    endtask

    task automatic test_arith();
        logic [10:0] ops[12] = '{OP_ADD, OP_SUB, OP_SUB, OP_MUL, OP_MUL, OP_MUL, OP_MUL,
                                 OP_DIV, OP_DIV, OP_ADD, OP_ADD, OP_SUB};
        logic [31:0] as[12]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3FC0_0000,
                                 32'hBFC0_0000, 32'h7F7F_FFFF, 32'h0080_0000, 32'h3F80_0000,
                                 32'h40C0_0000, 32'h3F80_0000, 32'h3F80_0001, 32'h4000_0000};
        logic [31:0] bs[12]  = '{32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000,
                                 32'h4000_0000, 32'h4000_0000, 32'h0080_0000, 32'h4040_0000,
                                 32'h4040_0000, 32'h3380_0000, 32'h3380_0000, 32'h3F80_0000};
        logic [31:0] es[12]  = '{32'h4040_0000, 32'hBF80_0000, 32'h0000_0000, 32'h4040_0000,
                                 32'hC040_0000, 32'h7F80_0000, 32'h0000_0000, 32'h3EAA_AAAB,
                                 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0002, 32'h3F80_0000};
        string       nms[12] = '{"add_1p2", "sub_1m2", "sub_cancel", "mul_1p5x2", "mul_neg",
                                 "mul_overflow", "mul_underflow", "div_1d3_round", "div_6d3",
                                 "add_tie_even", "add_tie_up", "sub_2m1"};
        logic [31:0] e;
        string       nm;
        for (int i = 0; i < 12; i++) begin
            push_vec(ops[i], as[i], bs[i], es[i], nms[i]);
            @(posedge clk);
            #1;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            n_checks++;
            if (bus.resultat !== e) begin
                n_fail++;
                $display("FAIL %s: got %08h expected %08h", nm, bus.resultat, e);
            end
        end
    endtask

    task automatic test_specials();
        logic [10:0] ops[9] = '{OP_DIV, OP_DIV, OP_ADD, OP_SUB, OP_MUL, OP_ADD, OP_DIV, OP_DIV, OP_ADD};
        logic [31:0] as[9]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0001, 32'h7F80_0000,
                                32'h0000_0000, 32'h7F80_0000, 32'hBF80_0000, 32'h7F80_0000,
                                32'h0000_0001};
        logic [31:0] bs[9]  = '{32'h0000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h7F80_0000,
                                32'hFF80_0000, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000,
                                32'h3F80_0000};
        logic [31:0] es[9]  = '{32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000,
                                32'h7FC0_0000, 32'h7F80_0000, 32'h8000_0000, 32'h7FC0_0000,
                                32'h3F80_0000};
        string       nms[9] = '{"div_by_zero", "div_0d0", "nan_in", "inf_minus_inf", "zero_x_inf",
                                "inf_plus_1", "x_div_inf", "inf_div_inf", "denorm_flush"};
        logic [31:0] e;
        string       nm;
        for (int i = 0; i < 9; i++) begin
            push_vec(ops[i], as[i], bs[i], es[i], nms[i]);
            @(posedge clk);
            #1;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            n_checks++;
            if (bus.resultat !== e) begin
                n_fail++;
                $display("FAIL %s: got %08h expected %08h", nm, bus.resultat, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        string       nm;
        push_vec(OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, "b2b_add");
        push_vec(OP_MUL, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, "b2b_mul");
        push_vec(OP_DIV, 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, "b2b_div");
        push_vec(OP_SUB, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, "b2b_sub");
        // Vectors changed every negedge; only the newest is visible one edge after it was driven.
        #1;
        e  = exp_q[$];
        nm = nm_q[$];
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.resultat !== e) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, bus.resultat, e);
        end
        exp_q.delete();
        nm_q.delete();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       push_vec(OP_MUL, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, "b2b_seq_mul");
                1:       push_vec(OP_DIV, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, "b2b_seq_div0");
                default: push_vec(OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, "b2b_seq_add");
            endcase
            @(posedge clk);
            #1;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            n_checks++;
            if (bus.resultat !== e) begin
                n_fail++;
                $display("FAIL %s: got %08h expected %08h", nm, bus.resultat, e);
            end
        end
    endtask

    task automatic test_mid_reset_invalid();
        logic [31:0] e;
        string       nm;
        push_vec(OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, "pre_reset_add");
        @(posedge clk);
        #1;
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        n_checks++;
        if (bus.resultat !== e) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, bus.resultat, e);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.resultat !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %08h expected 00000000", bus.resultat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(32'h4040_0000);
        nm_q.push_back("recompute_after_reset");
        @(posedge clk);
        #1;
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        n_checks++;
        if (bus.resultat !== e) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, bus.resultat, e);
        end
        push_vec(11'd5, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000, "invalid_op5");
        push_vec(11'h7FF, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000, "invalid_op7ff");
        exp_q.delete();
        nm_q.delete();
        exp_q.push_back(32'h0000_0000);
        nm_q.push_back("invalid_opcode");
        @(posedge clk);
        #1;
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        n_checks++;
        if (bus.resultat !== e) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, bus.resultat, e);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_specials();
        test_back_to_back();
        test_mid_reset_invalid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
